// File: rtl/vga_scanout_pkg.sv
// -----------------------------------------------------------------------------
// vga_scanout_pkg
//   Shared definitions for the AXI4-Stream to VGA scan-out controller:
//   default 640x480@60 raster timing, the scan-out state encoding and the
//   helper that sizes the raster counters.
// -----------------------------------------------------------------------------
package vga_scanout_pkg;

   // Default pixel width and 640x480@60 raster timing (pixel clock ~25.175 MHz)
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC_LEN = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC_LEN = 2;
   localparam int DEF_V_BP       = 33;

   // Width of the saturating error counters
   localparam int ERR_CNT_W = 16;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } scan_state_t;

   // Counter width for a counter that runs 0 .. total-1
   function automatic int cnt_w(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running horizontal/vertical raster counters and the position flags
//   derived from them. All flags are combinational on the current counter
//   position; the caller registers whatever it drives off-chip.
//
// Ports
//   clk          in   pixel clock, rising edge
//   rst          in   synchronous active-high reset, counters to (0,0)
//   act          out  current position is inside the active picture
//   hsync_on     out  current position is inside the HSYNC pulse (active high)
//   vsync_on     out  current line is inside the VSYNC pulse (active high)
//   frame_end    out  last clock of the raster frame
//   line_end_act out  last active pixel column of a line
//   origin       out  position (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_scanout_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC_LEN = DEF_H_SYNC_LEN,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC_LEN = DEF_V_SYNC_LEN,
   parameter int V_BP       = DEF_V_BP
)(
   input  logic clk,
   input  logic rst,
   output logic act,
   output logic hsync_on,
   output logic vsync_on,
   output logic frame_end,
   output logic line_end_act,
   output logic origin
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_LEN + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_LEN + V_BP;
   localparam int HW      = cnt_w(H_TOTAL);
   localparam int VW      = cnt_w(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   // Sync ranges held as inclusive bounds so the upper bound always fits the
   // counter width, even when the back porch is zero.
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC_LEN - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC_LEN - 1);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   // Counters never stall: the raster runs regardless of stream state.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign act          = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign hsync_on     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   assign vsync_on     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
   assign frame_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign line_end_act = (h_cnt == H_ACT_LAST);
   assign origin       = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/axis_vga_scanout_ctrl.sv
// -----------------------------------------------------------------------------
// axis_vga_scanout_ctrl
//   Scan-out controller between an AXI4-Stream pixel source and VGA pins.
//   Owns the raster (via vga_timing_gen), throttles the stream so exactly one
//   beat is consumed per active pixel, locks stream frames (TUSER) to raster
//   frames and drops back to WAIT_SOF on underflow or a misplaced SOF, picking
//   up again at the next raster frame boundary.
//
//   Sync pulse widths are H_SYNC_LEN / V_SYNC_LEN because H_SYNC / V_SYNC are
//   taken by the output pins.
//
//   Build option: define SCANOUT_ERR_CNT_EN to add the 16-bit saturating
//   error counters err_underflow_cnt, err_sof_cnt and err_eol_cnt.
//
// Ports
//   ACLK      in   pixel clock, rising edge
//   ARESET    in   synchronous active-high reset
//   TDATA     in   stream pixel
//   TVALID    in   stream valid
//   TUSER     in   start of frame, on the first pixel
//   TLAST     in   end of line, on the last pixel of each line
//   TREADY    out  stream ready (combinational)
//   H_SYNC    out  horizontal sync, active low, registered
//   V_SYNC    out  vertical sync, active low, registered
//   DATA_EN   out  active video, registered
//   pixel     out  output pixel, registered
//   locked    out  controller is in ACTIVE
//   underflow out  one-cycle pulse: stream starved in the active area
//   sof_err   out  one-cycle pulse: SOF beat away from pixel (0,0)
//   eol_err   out  one-cycle pulse: TLAST disagrees with the line end
//   err_*_cnt out  (SCANOUT_ERR_CNT_EN only) saturating error counters
// -----------------------------------------------------------------------------
module axis_vga_scanout_ctrl
   import vga_scanout_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC_LEN = DEF_H_SYNC_LEN,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC_LEN = DEF_V_SYNC_LEN,
   parameter int V_BP       = DEF_V_BP
)(
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [DATA_W-1:0] TDATA,
   input  logic              TVALID,
   input  logic              TUSER,
   input  logic              TLAST,
   output logic              TREADY,
   output logic              H_SYNC,
   output logic              V_SYNC,
   output logic              DATA_EN,
   output logic [DATA_W-1:0] pixel,
   output logic              locked,
   output logic              underflow,
   output logic              sof_err,
   output logic              eol_err
`ifdef SCANOUT_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_underflow_cnt,
   output logic [ERR_CNT_W-1:0] err_sof_cnt,
   output logic [ERR_CNT_W-1:0] err_eol_cnt
`endif
);

   // ---- stage p0: raster position and stream handshake ----
   logic act_p0;
   logic hsync_on_p0;
   logic vsync_on_p0;
   logic frame_end_p0;
   logic eol_pos_p0;
   logic origin_p0;
   logic sof_bad_p0;

   scan_state_t state;

   vga_timing_gen #(
      .H_ACTIVE   (H_ACTIVE),
      .H_FP       (H_FP),
      .H_SYNC_LEN (H_SYNC_LEN),
      .H_BP       (H_BP),
      .V_ACTIVE   (V_ACTIVE),
      .V_FP       (V_FP),
      .V_SYNC_LEN (V_SYNC_LEN),
      .V_BP       (V_BP)
   ) u_timing (
      .clk          (ACLK),
      .rst          (ARESET),
      .act          (act_p0),
      .hsync_on     (hsync_on_p0),
      .vsync_on     (vsync_on_p0),
      .frame_end    (frame_end_p0),
      .line_end_act (eol_pos_p0),
      .origin       (origin_p0)
   );

   // A SOF marker anywhere but (0,0) must not be swallowed while locked: the
   // beat is left upstream so that it can start the next frame after resync.
   assign sof_bad_p0 = TUSER && !origin_p0;

   // WAIT_SOF flushes non-SOF beats and parks on the SOF beat until the raster
   // wraps; ACTIVE takes exactly one beat per active pixel.
   always_comb begin
      TREADY = 1'b0;
      if (state == ACTIVE) begin
         TREADY = act_p0 && !sof_bad_p0;
      end else begin
         TREADY = ~TUSER;
      end
   end

   // ---- stage p1: registered pins, FSM and error pulses ----
   logic              hsync_p1;
   logic              vsync_p1;
   logic              vld_p1;
   logic [DATA_W-1:0] pixel_p1;
   logic              uf_p1;
   logic              sof_err_p1;
   logic              eol_err_p1;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= WAIT_SOF;
         hsync_p1   <= 1'b1;
         vsync_p1   <= 1'b1;
         vld_p1     <= 1'b0;
         pixel_p1   <= '0;
         uf_p1      <= 1'b0;
         sof_err_p1 <= 1'b0;
         eol_err_p1 <= 1'b0;
      end else begin
         hsync_p1   <= ~hsync_on_p0;
         vsync_p1   <= ~vsync_on_p0;
         vld_p1     <= act_p0;
         pixel_p1   <= '0;
         uf_p1      <= 1'b0;
         sof_err_p1 <= 1'b0;
         eol_err_p1 <= 1'b0;

         case (state)
            WAIT_SOF: begin
               // SOF beat is already waiting; it is consumed at (0,0) next cycle
               if (frame_end_p0 && TVALID && TUSER) begin
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (act_p0) begin
                  if (!TVALID) begin
                     // Raster keeps running; show black and resync next frame
                     uf_p1 <= 1'b1;
                     state <= WAIT_SOF;
                  end else if (sof_bad_p0) begin
                     sof_err_p1 <= 1'b1;
                     state      <= WAIT_SOF;
                  end else begin
                     pixel_p1   <= TDATA;
                     // Line-length mismatch is reported but the frame is kept
                     eol_err_p1 <= (TLAST != eol_pos_p0);
                  end
               end
            end
            default: state <= WAIT_SOF;
         endcase
      end
   end

   assign H_SYNC    = hsync_p1;
   assign V_SYNC    = vsync_p1;
   assign DATA_EN   = vld_p1;
   assign pixel     = pixel_p1;
   assign locked    = (state == ACTIVE);
   assign underflow = uf_p1;
   assign sof_err   = sof_err_p1;
   assign eol_err   = eol_err_p1;

`ifdef SCANOUT_ERR_CNT_EN
   // ---- stage p2: error statistics ----
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         err_underflow_cnt <= '0;
         err_sof_cnt       <= '0;
         err_eol_cnt       <= '0;
      end else begin
         if (uf_p1) begin
            err_underflow_cnt <= sat_inc(err_underflow_cnt);
         end
         if (sof_err_p1) begin
            err_sof_cnt <= sat_inc(err_sof_cnt);
         end
         if (eol_err_p1) begin
            err_eol_cnt <= sat_inc(err_eol_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_vga_scanout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_vga_scanout_ctrl
//   Directed bench on a tiny 8x6 raster (4x3 active). Stream frames carry
//   pixels 0x00..0x0B, TUSER on beat 0 and TLAST on every 4th beat.
// -----------------------------------------------------------------------------
module tb_axis_vga_scanout_ctrl;

   localparam int DATA_W = 8;

   logic              ACLK = 1'b0;
   logic              ARESET = 1'b1;
   logic [DATA_W-1:0] TDATA = '0;
   logic              TVALID = 1'b0;
   logic              TUSER = 1'b0;
   logic              TLAST = 1'b0;
   logic              TREADY;
   logic              H_SYNC;
   logic              V_SYNC;
   logic              DATA_EN;
   logic [DATA_W-1:0] pixel;
   logic              locked;
   logic              underflow;
   logic              sof_err;
   logic              eol_err;
`ifdef SCANOUT_ERR_CNT_EN
   logic [15:0]       err_underflow_cnt;
   logic [15:0]       err_sof_cnt;
   logic [15:0]       err_eol_cnt;
`endif

   axis_vga_scanout_ctrl #(
      .DATA_W     (DATA_W),
      .H_ACTIVE   (4),
      .H_FP       (1),
      .H_SYNC_LEN (2),
      .H_BP       (1),
      .V_ACTIVE   (3),
      .V_FP       (1),
      .V_SYNC_LEN (1),
      .V_BP       (1)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .TDATA     (TDATA),
      .TVALID    (TVALID),
      .TUSER     (TUSER),
      .TLAST     (TLAST),
      .TREADY    (TREADY),
      .H_SYNC    (H_SYNC),
      .V_SYNC    (V_SYNC),
      .DATA_EN   (DATA_EN),
      .pixel     (pixel),
      .locked    (locked),
      .underflow (underflow),
      .sof_err   (sof_err),
      .eol_err   (eol_err)
`ifdef SCANOUT_ERR_CNT_EN
      ,
      .err_underflow_cnt (err_underflow_cnt),
      .err_sof_cnt       (err_sof_cnt),
      .err_eol_cnt       (err_eol_cnt)
`endif
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;
   int bh = 0, bv = 0;   // raster position of the current cycle
   int ph = 0, pv = 0;   // position whose outputs are visible now
   int beat = 0;         // index of the beat the source presents (0..11)
   int acc = 0;          // accepted beats
   bit hs;
   bit src_vld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (pos h=%0d v=%0d)", tag, obs, exp, ph, pv);
      end
   endtask

   // Present the current source beat.
   task automatic drive();
      TVALID = src_vld;
      TDATA  = 8'(beat);
      TUSER  = (beat == 0);
      TLAST  = ((beat % 4) == 3);
   endtask

   // One clock: record handshake before the edge, sample 1 ns after it.
   task automatic cyc();
      #1;
      hs = TVALID && TREADY;
      ph = bh;
      pv = bv;
      @(posedge ACLK);
      #1;
      if (hs) begin
         beat = (beat + 1) % 12;
         acc++;
      end
      if (ARESET) begin
         bh = 0;
         bv = 0;
      end else if (bh == 7) begin
         bh = 0;
         bv = (bv == 5) ? 0 : bv + 1;
      end else begin
         bh++;
      end
   endtask

   // Check the outputs for position (ph,pv) against the raster definition.
   task automatic check_raster(input bit exp_lock, input bit pix_on, input bit chk_pix,
                               input bit e_uf, input bit e_sof, input bit e_eol);
      bit act;
      act = (ph < 4) && (pv < 3);
      chk("data_en", DATA_EN, act);
      chk("h_sync", H_SYNC, !(ph == 5 || ph == 6));
      chk("v_sync", V_SYNC, !(pv == 4));
      chk("locked", locked, exp_lock);
      if (chk_pix) chk("pixel", pixel, (pix_on && act) ? pv * 4 + ph : 0);
      chk("underflow", underflow, e_uf);
      chk("sof_err", sof_err, e_sof);
      chk("eol_err", eol_err, e_eol);
   endtask

   initial begin
      // Reset
      ARESET = 1'b1;
      src_vld = 1'b0;
      beat = 0;
      drive();
      cyc();
      cyc();
      chk("rst_h_sync", H_SYNC, 1);
      chk("rst_v_sync", V_SYNC, 1);
      chk("rst_data_en", DATA_EN, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_locked", locked, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_sof_err", sof_err, 0);
      chk("rst_eol_err", eol_err, 0);
      ARESET = 1'b0;

      // Two idle frames: raster only, blank pixels, never locked
      for (int i = 0; i < 96; i++) begin
         drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);
      end

      // Source always valid: SOF beat parks until the frame boundary
      src_vld = 1'b1;
      beat = 0;
      for (int i = 0; i < 47; i++) begin
         drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);
      end
      drive(); cyc(); check_raster(1, 0, 1, 0, 0, 0);
      for (int f = 0; f < 2; f++) begin
         acc = 0;
         for (int i = 0; i < 48; i++) begin
            drive(); cyc(); check_raster(1, 1, 1, 0, 0, 0);
         end
         chk("beats_per_frame", acc, 12);
      end

      // Underflow at pixel (2,1)
      for (int i = 0; i < 10; i++) begin
         drive(); cyc(); check_raster(1, 1, 1, 0, 0, 0);
      end
      drive(); TVALID = 1'b0; cyc(); check_raster(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 36; i++) begin
         drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);
      end
      drive(); cyc(); check_raster(1, 0, 1, 0, 0, 0);
      acc = 0;
      for (int i = 0; i < 48; i++) begin
         drive(); cyc(); check_raster(1, 1, 1, 0, 0, 0);
      end
      chk("relock_beats", acc, 12);

      // Misplaced SOF at pixel (1,0)
      drive(); cyc(); check_raster(1, 1, 1, 0, 0, 0);
      drive(); TUSER = 1'b1;
      #1;
      chk("sof_tready", TREADY, 0);
      acc = 0;
      cyc(); check_raster(0, 0, 0, 0, 1, 0);
      chk("sof_beat_held", acc, 0);
      for (int i = 0; i < 45; i++) begin
         drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);
      end
      drive(); cyc(); check_raster(1, 0, 1, 0, 0, 0);

      // TLAST early at (2,0) and missing at (3,1): reported, lock kept
      acc = 0;
      for (int i = 0; i < 48; i++) begin
         drive();
         if (i == 2) TLAST = 1'b1;
         if (i == 11) TLAST = 1'b0;
         cyc();
         check_raster(1, 1, 1, 0, 0, (i == 2) || (i == 11));
      end
      chk("eol_beats", acc, 12);

`ifdef SCANOUT_ERR_CNT_EN
      chk("cnt_underflow", err_underflow_cnt, 1);
      chk("cnt_sof", err_sof_cnt, 1);
      chk("cnt_eol", err_eol_cnt, 2);
`endif

      // Reset in the middle of active line 1
      for (int i = 0; i < 10; i++) begin
         drive(); cyc(); check_raster(1, 1, 1, 0, 0, 0);
      end
      ARESET = 1'b1;
      drive(); cyc();
      chk("mid_rst_h_sync", H_SYNC, 1);
      chk("mid_rst_v_sync", V_SYNC, 1);
      chk("mid_rst_data_en", DATA_EN, 0);
      chk("mid_rst_pixel", pixel, 0);
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_underflow", underflow, 0);
      chk("mid_rst_sof_err", sof_err, 0);
      chk("mid_rst_eol_err", eol_err, 0);
`ifdef SCANOUT_ERR_CNT_EN
      chk("mid_rst_cnt_underflow", err_underflow_cnt, 0);
      chk("mid_rst_cnt_sof", err_sof_cnt, 0);
      chk("mid_rst_cnt_eol", err_eol_cnt, 0);
`endif
      ARESET = 1'b0;
      src_vld = 1'b0;
      // Counters restart at (0,0): DATA_EN returns immediately
      drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);
      drive(); cyc(); check_raster(0, 0, 1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
